// File: rtl/pdm_capture.sv
// PDM microphone front end: generates the mic clock, boxcar-decimates the 1-bit
// stream into unsigned PCM and hands samples out over valid/ready.
// Optional `PDM_DROP_COUNT_EN adds an 8-bit saturating dropped-sample counter.
module pdm_capture #(
  parameter int SAMPLE_WIDTH    = 16,
  parameter int CLK_HALF_PERIOD = 50,
  parameter int DECIMATION      = 64,
  parameter int WARMUP_WINDOWS  = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    pdm_data_i,
  output logic                    pdm_clk_o,
  output logic                    pdm_lrsel_o,
  output logic [SAMPLE_WIDTH-1:0] sample_o,
  output logic                    sample_valid_o,
  input  logic                    sample_ready_i,
  output logic                    overrun_o,
  output logic                    busy_o
`ifdef PDM_DROP_COUNT_EN
  ,
  output logic [7:0]              drop_count_o
`endif
);

  localparam int LOG2D = $clog2(DECIMATION);
  localparam int CW    = LOG2D + 1;
  localparam int SHIFT = SAMPLE_WIDTH - LOG2D;
  localparam int DW    = (CLK_HALF_PERIOD > 1) ? $clog2(CLK_HALF_PERIOD) : 1;
  localparam int WW    = (WARMUP_WINDOWS > 0) ? $clog2(WARMUP_WINDOWS + 1) : 1;
  localparam logic [DW-1:0] DIV_TC    = DW'(CLK_HALF_PERIOD - 1);
  localparam logic [CW-1:0] WIN_END   = CW'(DECIMATION);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_WINDOWS - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t                  state;
  logic [DW-1:0]           div_cnt;
  logic [CW-1:0]           bit_cnt;
  logic [CW-1:0]           ones_cnt;
  logic [WW-1:0]           warm_cnt;
  logic                    enable_q;
  logic [SAMPLE_WIDTH:0]   pcm_wide;
  logic [SAMPLE_WIDTH-1:0] pcm;
  logic                    win_end;
  logic                    publish;
  logic                    xfer;
  logic                    en_rise;

  assign pdm_lrsel_o = 1'b0;

  // Only ones_cnt == DECIMATION reaches the extra top bit, so that is the saturating case.
  assign pcm_wide = {ones_cnt, {SHIFT{1'b0}}};
  assign pcm      = pcm_wide[SAMPLE_WIDTH] ? '1 : pcm_wide[SAMPLE_WIDTH-1:0];
  assign win_end  = (bit_cnt == WIN_END);
  assign publish  = win_end && (state == RUN) && enable_i;
  assign xfer     = sample_valid_o && sample_ready_i;
  assign en_rise  = enable_i && !enable_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      div_cnt   <= '0;
      pdm_clk_o <= 1'b0;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      warm_cnt  <= '0;
      enable_q  <= 1'b0;
    end else begin
      enable_q <= enable_i;
      if (!enable_i) begin
        state     <= IDLE;
        busy_o    <= 1'b0;
        div_cnt   <= '0;
        pdm_clk_o <= 1'b0;
        bit_cnt   <= '0;
        ones_cnt  <= '0;
        warm_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            warm_cnt <= '0;
            busy_o   <= 1'b1;
            state    <= (WARMUP_WINDOWS == 0) ? RUN : WARMUP;
          end
          WARMUP: begin
            if (win_end) begin
              warm_cnt <= warm_cnt + WW'(1);
              if (warm_cnt == WARM_LAST) state <= RUN;
            end
          end
          default: ;
        endcase

        if (state != IDLE) begin
          // Window end is the cycle after the last capture; with a half period
          // of at least 2 it can never coincide with the next capture edge.
          if (win_end) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
          end else if (div_cnt == DIV_TC && pdm_clk_o) begin
            bit_cnt  <= bit_cnt + CW'(1);
            ones_cnt <= ones_cnt + CW'(pdm_data_i);
          end
          if (div_cnt == DIV_TC) begin
            div_cnt   <= '0;
            pdm_clk_o <= ~pdm_clk_o;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
      end
    end
  end

  // Single-entry holding register; a publish into a stalled entry is dropped.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
`ifdef PDM_DROP_COUNT_EN
      drop_count_o   <= '0;
`endif
    end else begin
      if (en_rise) begin
        overrun_o    <= 1'b0;
`ifdef PDM_DROP_COUNT_EN
        drop_count_o <= '0;
`endif
      end
      if (publish) begin
        if (sample_valid_o && !sample_ready_i) begin
          overrun_o <= 1'b1;
`ifdef PDM_DROP_COUNT_EN
          if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
`endif
        end else begin
          sample_o       <= pcm;
          sample_valid_o <= 1'b1;
        end
      end else if (xfer) begin
        sample_valid_o <= 1'b0;
      end
    end
  end

endmodule
